// File: rtl/capture_sequencer.sv
// Arms, triggers and gates a window of lockstep ADC beats into NCHAN readout buffers.
// Optional CAPSEQ_TSTAMP_EN adds a 48-bit beat timestamp latched at the trigger.
module capture_sequencer #(
  parameter int DATA_WIDTH = 128,
  parameter int NCHAN      = 4,
  parameter int LEN_WIDTH  = 16,
  parameter int TRIG_QUAL  = 4
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        arm,
  input  logic                        abort,
  input  logic                        force_trig,
  input  logic                        trigger,
  input  logic [LEN_WIDTH-1:0]        capture_len,
  input  logic [NCHAN*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [NCHAN*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [NCHAN-1:0]            m_axis_tvalid,
  input  logic [NCHAN-1:0]            m_axis_tready,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic [LEN_WIDTH-1:0]        beat_count
`ifdef CAPSEQ_TSTAMP_EN
  ,
  output logic [47:0]                 trig_tstamp
`endif
);
  localparam int QW = $clog2(TRIG_QUAL + 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t         state;
  logic [QW-1:0]  qual;
  logic [LEN_WIDTH-1:0] len;
  logic           qual_hit;
  logic           trig_go;
  logic           take;

  assign s_axis_tready = 1'b1;
  assign busy = (state == ARMED) || (state == CAPTURE);
  assign done = (state == DONE);

  // The beat that completes qualification is itself the first captured beat.
  assign qual_hit = (state == ARMED) && s_axis_tvalid && trigger &&
                    (qual == QW'(TRIG_QUAL - 1));
  assign trig_go  = (state == ARMED) && (force_trig || qual_hit);
  assign take     = s_axis_tvalid && ((state == CAPTURE) || trig_go);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      qual          <= '0;
      len           <= LEN_WIDTH'(1);
      beat_count    <= '0;
      overflow      <= 1'b0;
      m_axis_tvalid <= '0;
      m_axis_tdata  <= '0;
    end else begin
      m_axis_tvalid <= '0;
      // Refused beats are dropped, not retried; buffers stay beat-aligned.
      if (|(m_axis_tvalid & ~m_axis_tready)) overflow <= 1'b1;
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (arm) begin
              state      <= ARMED;
              len        <= (capture_len == '0) ? LEN_WIDTH'(1) : capture_len;
              overflow   <= 1'b0;
              beat_count <= '0;
              qual       <= '0;
            end
          end
          ARMED: begin
            if (trig_go) state <= CAPTURE;
            else if (s_axis_tvalid) qual <= trigger ? qual + 1'b1 : '0;
          end
          default: ;
        endcase
        if (take) begin
          m_axis_tvalid <= '1;
          m_axis_tdata  <= s_axis_tdata;
          beat_count    <= beat_count + 1'b1;
          if (beat_count + 1'b1 == len) state <= DONE;
        end
      end
    end
  end

`ifdef CAPSEQ_TSTAMP_EN
  logic [47:0] ts_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ts_cnt      <= '0;
      trig_tstamp <= '0;
    end else begin
      if (s_axis_tvalid) ts_cnt <= ts_cnt + 1'b1;
      if (trig_go && !abort) trig_tstamp <= ts_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: spec-level model checked every cycle plus literal pins.
module tb_capture_sequencer;
  localparam int DW = 128, NC = 4, LW = 16, TQ = 4;

  logic              aclk = 1'b0;
  logic              aresetn, arm, abort, force_trig, trigger, s_axis_tvalid;
  logic [LW-1:0]     capture_len;
  logic [NC*DW-1:0]  s_axis_tdata, m_axis_tdata;
  logic              s_axis_tready, busy, done, overflow;
  logic [NC-1:0]     m_axis_tvalid, m_axis_tready;
  logic [LW-1:0]     beat_count;
`ifdef CAPSEQ_TSTAMP_EN
  logic [47:0]       trig_tstamp;
`endif

  capture_sequencer #(.DATA_WIDTH(DW), .NCHAN(NC), .LEN_WIDTH(LW), .TRIG_QUAL(TQ)) dut (
    .aclk(aclk), .aresetn(aresetn), .arm(arm), .abort(abort), .force_trig(force_trig),
    .trigger(trigger), .capture_len(capture_len), .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .busy(busy), .done(done), .overflow(overflow),
    .beat_count(beat_count)
`ifdef CAPSEQ_TSTAMP_EN
    , .trig_tstamp(trig_tstamp)
`endif
  );

  always #5 aclk = ~aclk;

  int compared = 0, mismatched = 0;
  int seq = 0;
  int nv [NC];
  int first_tag;
  bit got_first;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [NC*DW-1:0] mk(input int s);
    logic [NC*DW-1:0] r;
    for (int ch = 0; ch < NC; ch++) r[ch*DW +: DW] = DW'({32'(ch), 32'(s)});
    return r;
  endfunction

  // Model: mode 0 idle, 1 armed, 2 capture, 3 done; outputs are what must be visible after the edge
  int              m_mode, m_q, m_len, m_bc;
  bit              m_tv, m_ovf;
  logic [NC*DW-1:0] m_data;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_mode = 0; m_q = 0; m_len = 1; m_bc = 0; m_tv = 0; m_ovf = 0; m_data = '0;
    end else begin
      bit cap;
      cap = 0;
      if (m_tv && m_axis_tready != '1) m_ovf = 1;
      m_tv = 0;
      if (abort) m_mode = 0;
      else begin
        case (m_mode)
          0, 3: if (arm) begin
            m_len = (capture_len == 0) ? 1 : int'(capture_len);
            m_ovf = 0; m_bc = 0; m_q = 0; m_mode = 1;
          end
          1: if (force_trig) begin
            m_mode = 2; cap = s_axis_tvalid;
          end else if (s_axis_tvalid) begin
            m_q = trigger ? m_q + 1 : 0;
            if (m_q == TQ) begin cap = 1; m_mode = 2; end
          end
          2: cap = s_axis_tvalid;
          default: ;
        endcase
        if (cap) begin
          m_tv = 1; m_data = s_axis_tdata; m_bc++;
          if (m_bc == m_len) m_mode = 3;
        end
      end
    end
  end

  always @(negedge aclk) begin
    chk("tvalid", 64'(m_axis_tvalid), 64'({NC{m_tv}}));
    chk("busy", 64'(busy), 64'(m_mode == 1 || m_mode == 2));
    chk("done", 64'(done), 64'(m_mode == 3));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("beat_count", 64'(beat_count), 64'(m_bc));
    chk("s_tready", 64'(s_axis_tready), 64'd1);
    if (m_tv) begin
      compared++;
      if (m_axis_tdata !== m_data) begin
        mismatched++;
        $display("FAIL tdata: got %0h expected %0h", m_axis_tdata[63:0], m_data[63:0]);
      end
    end
    for (int ch = 0; ch < NC; ch++) if (m_axis_tvalid[ch]) nv[ch]++;
    if (m_axis_tvalid[0] && !got_first) begin
      got_first = 1; first_tag = int'(m_axis_tdata[31:0]);
    end
  end

  task automatic clr_obs();
    for (int ch = 0; ch < NC; ch++) nv[ch] = 0;
    got_first = 0; first_tag = -1;
  endtask

  task automatic beat(input bit tv, input bit tr);
    s_axis_tvalid = tv; trigger = tr;
    if (tv) begin s_axis_tdata = mk(seq); seq++; end
    @(posedge aclk); #1;
    arm = 0; abort = 0; force_trig = 0; s_axis_tvalid = 0;
  endtask

  task automatic do_arm(input int l);
    capture_len = LW'(l); arm = 1; beat(0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(0, 0);
  endtask

  task automatic chk_counts(input string n, input int e);
    for (int ch = 0; ch < NC; ch++) chk($sformatf("%s_ch%0d", n, ch), 64'(nv[ch]), 64'(e));
  endtask

  int tag;

  initial begin
    aresetn = 0; arm = 0; abort = 0; force_trig = 0; trigger = 0; s_axis_tvalid = 0;
    capture_len = '0; s_axis_tdata = '0; m_axis_tready = '1;
    clr_obs();
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tdata", 64'(|m_axis_tdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_bc", 64'(beat_count), 64'd0);
    chk("rst_tready", 64'(s_axis_tready), 64'd1);
    aresetn = 1;
    idle(2);

    // qualified trigger, 8 beats
    clr_obs(); do_arm(8);
    for (int i = 0; i < 4; i++) begin if (i == 3) tag = seq; beat(1, 1); end
    for (int i = 0; i < 7; i++) beat(1, 0);
    idle(3);
    chk_counts("t1_count", 8);
    chk("t1_first", 64'(first_tag), 64'(tag));
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_bc", 64'(beat_count), 64'd8);
    chk("t1_ovf", 64'(overflow), 64'd0);

    // broken trigger run restarts qualification; invalid beat leaves count alone
    clr_obs(); do_arm(4);
    beat(1, 1); beat(1, 1); beat(1, 1); beat(0, 1); beat(1, 0);
    beat(1, 1); beat(1, 1); beat(1, 1);
    chk_counts("t2_pre", 0);
    tag = seq; beat(1, 1);
    for (int i = 0; i < 3; i++) beat(1, 0);
    idle(2);
    chk_counts("t2_count", 4);
    chk("t2_first", 64'(first_tag), 64'(tag));

    // force with len 0 -> single beat; force in DONE ignored
    clr_obs(); do_arm(0);
    tag = seq; force_trig = 1; beat(1, 0);
    for (int i = 0; i < 3; i++) beat(1, 0);
    force_trig = 1; beat(1, 0);
    idle(2);
    chk_counts("t3_count", 1);
    chk("t3_first", 64'(first_tag), 64'(tag));
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_bc", 64'(beat_count), 64'd1);

    // force on an invalid cycle: next valid beat is first
    clr_obs(); do_arm(2);
    force_trig = 1; beat(0, 0);
    idle(1);
    tag = seq; beat(1, 0); beat(1, 0); beat(1, 0);
    idle(2);
    chk_counts("t3b_count", 2);
    chk("t3b_first", 64'(first_tag), 64'(tag));

    // refused beat on buffer 2; arm mid-capture ignored
    clr_obs(); do_arm(16);
    force_trig = 1;
    for (int i = 0; i < 20; i++) begin
      m_axis_tready = (i == 8) ? 4'b1011 : 4'b1111;
      if (i == 10) arm = 1;
      beat(1, 0);
    end
    m_axis_tready = '1;
    idle(2);
    chk_counts("t4_count", 16);
    chk("t4_ovf", 64'(overflow), 64'd1);
    chk("t4_bc", 64'(beat_count), 64'd16);
    do_arm(3);
    chk("t4_ovf_clr", 64'(overflow), 64'd0);
    chk("t4_busy", 64'(busy), 64'd1);
    abort = 1; beat(0, 0);

    // abort after 5 of 10
    clr_obs(); do_arm(10);
    force_trig = 1; beat(1, 0);
    for (int i = 0; i < 4; i++) beat(1, 0);
    abort = 1; beat(1, 0);
    for (int i = 0; i < 5; i++) beat(1, 1);
    idle(1);
    chk_counts("t5_count", 5);
    chk("t5_bc", 64'(beat_count), 64'd5);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_done", 64'(done), 64'd0);

    // async reset mid-capture, then continuous traffic with trigger high
    do_arm(8);
    force_trig = 1; beat(1, 0);
    for (int i = 0; i < 3; i++) beat(1, 0);
    s_axis_tvalid = 1; s_axis_tdata = mk(seq); seq++;
    #1; aresetn = 0; clr_obs();
    @(posedge aclk); @(posedge aclk); #1;
    aresetn = 1;
    for (int i = 0; i < 10; i++) beat(1, 1);
    idle(1);
    chk_counts("t6_count", 0);
    chk("t6_bc", 64'(beat_count), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
